// File: rtl/mir_io_pkg.sv
// ============================================================================
// Module      : mir_io_pkg
// Description : Shared types and constants for the I/O interrupt handler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mir_io_pkg;

  localparam int IO_DATA_WIDTH = 32;

  localparam int INT_INPUT  = 1;
  localparam int INT_OUTPUT = 2;
  localparam int INT_END    = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_IN_WAIT  = 3'd1,
    ST_OUT_WAIT = 3'd2,
    ST_RELEASE  = 3'd3,
    ST_SETTLE   = 3'd4,
    ST_HALT     = 3'd5
  } io_state_t;

endpackage : mir_io_pkg

`default_nettype wire

// File: rtl/io_interrupt_handler_if.sv
// ============================================================================
// Module      : io_interrupt_handler_if
// Description : Interrupt, device handshake and writeback bundle of the
//               I/O interrupt handler. Counter signals exist only when
//               IO_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface io_interrupt_handler_if
  import mir_io_pkg::*;
#(
  parameter int DATA_WIDTH = IO_DATA_WIDTH,
  parameter int STAT_WIDTH = 16
);

  logic                  intrpt;
  logic [DATA_WIDTH-1:0] intrpt_val;
  logic [DATA_WIDTH-1:0] reg_data;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;
  logic                  wb_en;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  stall;
  logic                  halted;
`ifdef IO_STATS_EN
  logic [STAT_WIDTH-1:0] in_count;
  logic [STAT_WIDTH-1:0] out_count;
`endif

  if (STAT_WIDTH < 1 || DATA_WIDTH < 2) begin : g_param_check
    $error("io_interrupt_handler_if: illegal width parameters");
  end

  // Pipeline, devices and register file side
  modport master (
    output intrpt,
    output intrpt_val,
    output reg_data,
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  wb_en,
    input  wb_data,
    input  stall,
`ifdef IO_STATS_EN
    input  in_count,
    input  out_count,
`endif
    input  halted
  );

  // Handler side
  modport slave (
    input  intrpt,
    input  intrpt_val,
    input  reg_data,
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output wb_en,
    output wb_data,
    output stall,
`ifdef IO_STATS_EN
    output in_count,
    output out_count,
`endif
    output halted
  );

endinterface : io_interrupt_handler_if

`default_nettype wire

// File: rtl/io_sat_counter.sv
// ============================================================================
// Module      : io_sat_counter
// Description : Event counter that sticks at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule : io_sat_counter

`default_nettype wire

// File: rtl/io_interrupt_handler.sv
// ============================================================================
// Module      : io_interrupt_handler
// Description : Services input/output/program-end interrupt codes: stalls
//               the pipeline, runs the device handshakes, writes captured
//               input back and latches the halted state. Defining
//               IO_STATS_EN adds saturating in/out event counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_interrupt_handler
  import mir_io_pkg::*;
#(
  parameter int DATA_WIDTH = IO_DATA_WIDTH,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  io_interrupt_handler_if.slave bus
);

  if (STAT_WIDTH < 1 || DATA_WIDTH < 2) begin : g_param_check
    $error("io_interrupt_handler: illegal width parameters");
  end

  io_state_t             state_q;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic                  wb_en_q;
  logic                  halted_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [DATA_WIDTH-1:0] wb_data_q;

  logic is_input;
  logic is_output;
  logic is_end;
  logic code_valid;
  logic in_fire;
  logic out_fire;
  logic stall_c;

  assign is_input   = bus.intrpt && (bus.intrpt_val == DATA_WIDTH'(INT_INPUT));
  assign is_output  = bus.intrpt && (bus.intrpt_val == DATA_WIDTH'(INT_OUTPUT));
  assign is_end     = bus.intrpt && (bus.intrpt_val == DATA_WIDTH'(INT_END));
  assign code_valid = is_input || is_output || is_end;

  // in_ready_q / out_valid_q are only ever set in their own wait states
  assign in_fire  = bus.in_valid && in_ready_q;
  assign out_fire = out_valid_q && bus.out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      wb_en_q     <= 1'b0;
      halted_q    <= 1'b0;
      out_data_q  <= '0;
      wb_data_q   <= '0;
    end else begin
      wb_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (is_input) begin
            state_q    <= ST_IN_WAIT;
            in_ready_q <= 1'b1;
          end else if (is_output) begin
            state_q     <= ST_OUT_WAIT;
            out_valid_q <= 1'b1;
            out_data_q  <= bus.reg_data;
          end else if (is_end) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end
        end
        ST_IN_WAIT: begin
          if (in_fire) begin
            state_q    <= ST_RELEASE;
            in_ready_q <= 1'b0;
            wb_data_q  <= bus.in_data;
            wb_en_q    <= 1'b1;
          end
        end
        ST_OUT_WAIT: begin
          if (out_fire) begin
            state_q     <= ST_RELEASE;
            out_valid_q <= 1'b0;
          end
        end
        ST_RELEASE: begin
          state_q <= ST_SETTLE;
        end
        // The interruption stage still shows the serviced opcode here
        ST_SETTLE: begin
          state_q <= ST_IDLE;
        end
        ST_HALT: begin
          state_q  <= ST_HALT;
          halted_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          halted_q    <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    stall_c = 1'b0;
    case (state_q)
      ST_IN_WAIT, ST_OUT_WAIT, ST_HALT: stall_c = 1'b1;
      ST_IDLE:                          stall_c = code_valid;
      default:                          stall_c = 1'b0;
    endcase
  end

  assign bus.stall     = stall_c;
  assign bus.halted    = halted_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.wb_en     = wb_en_q;
  assign bus.wb_data   = wb_data_q;

`ifdef IO_STATS_EN
  io_sat_counter #(
    .WIDTH (STAT_WIDTH)
  ) u_in_count (
    .clock   (clock),
    .reset_n (reset_n),
    .inc_i   (in_fire),
    .count_o (bus.in_count)
  );

  io_sat_counter #(
    .WIDTH (STAT_WIDTH)
  ) u_out_count (
    .clock   (clock),
    .reset_n (reset_n),
    .inc_i   (out_fire),
    .count_o (bus.out_count)
  );
`endif

endmodule : io_interrupt_handler

`default_nettype wire

// File: doc/io_interrupt_handler.md
# io_interrupt_handler

Services the interrupt codes raised by the interruption stage, which registers `intrpt`/`intrpt_val` one cycle after decoding the input, output and program-end opcodes. It sits directly downstream of that stage and performs three jobs:
- stalls the PC/pipeline;
- runs valid/ready handshakes with the input device (switches) and the output device (display);
- writes captured input back to the register file, or latches the processor into a halted state.

## Interface
Parameters:
- DATA_WIDTH, 32, width of interrupt code, input, output and writeback data
- STAT_WIDTH, 16, width of event counters (used only with IO_STATS_EN)

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- intrpt  in  1  interrupt request from the interruption stage
- intrpt_val  in  DATA_WIDTH  interrupt code: 1 input, 2 output, 3 program end
- reg_data  in  DATA_WIDTH  source-register value to be displayed on an output interrupt
- in_valid  in  1  input device presents data
- in_data  in  DATA_WIDTH  input device data
- in_ready  out  1  handler accepts input
- out_valid  out  1  out_data is new and must be consumed
- out_data  out  DATA_WIDTH  display value, held until the next output interrupt
- out_ready  in  1  output device consumed out_data
- wb_en  out  1  one-cycle register-file write strobe
- wb_data  out  DATA_WIDTH  value to write
- stall  out  1  freeze PC/pipeline
- halted  out  1  program end reached
- in_count, out_count  out  STAT_WIDTH  event counters (only with IO_STATS_EN)

## Operation
- Code constants are INT_INPUT=1, INT_OUTPUT=2 and INT_END=3. Any other code with intrpt=1 is ignored: no stall, state unchanged.
- FSM states: IDLE, IN_WAIT, OUT_WAIT, RELEASE, SETTLE, HALT.
- IDLE:
  - intrpt=1 with INT_INPUT -> IN_WAIT.
  - intrpt=1 with INT_OUTPUT -> OUT_WAIT; capture reg_data into out_data on this edge.
  - intrpt=1 with INT_END -> HALT.
- IN_WAIT: in_ready=1. On in_valid&in_ready, register in_data into wb_data and go to RELEASE with the writeback flag set.
- OUT_WAIT: out_valid=1. On out_valid&out_ready go to RELEASE; out_data keeps its value afterwards.
- RELEASE: stall=0 and wb_en=1 if the writeback flag is set. Exactly one cycle, then SETTLE.
- SETTLE: stall=0. intrpt is ignored because the interruption stage still shows the old opcode. One cycle, then IDLE. This makes back-to-back I/O instructions each serviced exactly once.
- HALT: stall=1 and halted=1 permanently. Only reset_n exits this state.
- stall is combinational: 1 in IN_WAIT, OUT_WAIT and HALT, and also in IDLE when intrpt=1 with a valid code (1..3). Otherwise 0.
- in_ready and out_valid are registered state decodes. They never depend combinationally on in_valid or out_ready.

## Timing
- Reset (async assert, sync-safe release): state=IDLE; stall, halted, in_ready, out_valid, wb_en = 0; out_data and wb_data = 0; counters 0.
- Reset mid-handshake aborts the transaction: no wb_en pulse is issued and out_valid drops immediately.
- Latency, input: handshake edge -> wb_en high the following cycle. Minimum total for an input interrupt: IDLE detect, IN_WAIT, RELEASE, SETTLE = 4 cycles.
- Latency, output: out_data is valid and out_valid=1 one cycle after detect.
- in_valid may be held high before IN_WAIT is entered. It is accepted on the first IN_WAIT cycle.
- intrpt going low during IN_WAIT or OUT_WAIT has no effect; the transaction completes.
- A code change during IN_WAIT or OUT_WAIT is ignored.

## Configuration
- IO_STATS_EN defined:
  - in_count increments on each accepted input handshake.
  - out_count increments on each completed output handshake.
  - Both counters saturate at all-ones and are cleared by reset.
- IO_STATS_EN undefined: the counter ports and logic are absent. All other behaviour is identical.

## Structure
- Shared package mir_io_pkg holds:
  - the state enum io_state_t;
  - the code constants INT_INPUT, INT_OUTPUT and INT_END;
  - a default DATA_WIDTH localparam.
- One natural sub-module, io_sat_counter: a parameterised saturating counter instantiated twice, under IO_STATS_EN only.

## Test plan
- Input: intrpt=1 with val=1; in_valid=1 and in_data=0x0000_002A after 3 cycles -> stall high throughout the wait; wb_en pulses once with wb_data=0x2A the cycle after the handshake; stall=0 for exactly 2 cycles (RELEASE, SETTLE) before IDLE.
- Output: val=2 with reg_data=0xDEAD_BEEF; out_ready held 0 for 5 cycles then 1 -> out_valid=1 for 6 cycles; out_data=0xDEADBEEF stays after out_valid drops.
- Back-to-back: two consecutive output instructions with intrpt held high across the SETTLE cycle -> exactly two out_valid transactions, no duplicates.
- End: val=3 -> stall and halted stick high; a subsequent val=1 is ignored; reset_n low clears halted asynchronously.
- Abort/invalid: reset_n pulsed during IN_WAIT -> no wb_en and all outputs 0. Separately, intrpt=1 with val=7 -> no stall and the state stays IDLE.
- IO_STATS_EN with STAT_WIDTH=2: 5 input transactions -> in_count=3 (saturated) and out_count=0.
